// File: rtl/usb_tx_packetizer_if.sv
// usb_tx_packetizer_if: command, payload-source and UTMI transmit signals of the USB DATA packetizer
interface usb_tx_packetizer_if #(
    parameter int LEN_W = 7
);
    logic             send_data;
    logic [3:0]       pid;
    logic [LEN_W-1:0] len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic             err;
    modport master (
        output send_data, pid, len, in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, busy, done, err
    );
    modport slave (
        input  send_data, pid, len, in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: streams PID, payload and on-the-fly CRC16 of a USB DATA packet onto UTMI transmit
module usb_tx_packetizer #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input logic                clk,
    input logic                reset,
    usb_tx_packetizer_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] snt_q, snt_d;
    logic [7:0]       pf_q, pf_d;
    logic             pf_v_q, pf_v_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             in_rdy, acc, fetch, avail, abort;
    logic [7:0]       nxt_byte;
    logic [15:0]      crc_nxt;

    // Reflected CRC16 (poly 0xA001) advanced by one byte, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // A byte fetched this cycle may bypass the prefetch register straight onto tx_data,
    // so an accept never underruns while the source keeps pace with the UTMI side
    assign in_rdy   = (state_q == PID || state_q == DATA) && cnt_q < len_q && (!pf_v_q || bus.tx_ready);
    assign acc      = tx_valid_q && bus.tx_ready;
    assign fetch    = in_rdy && bus.in_valid;
    assign avail    = pf_v_q || fetch;
    assign nxt_byte = pf_v_q ? pf_q : bus.in_data;
    assign crc_nxt  = crc16_byte(crc_q, tx_data_q);

    assign bus.in_ready = in_rdy;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    // Next-state: packet sequencing, prefetch bookkeeping, CRC accumulation and status pulses
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        snt_d      = snt_q;
        pf_d       = pf_q;
        pf_v_d     = pf_v_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        abort      = 1'b0;
        if (fetch) begin
            pf_d   = bus.in_data;
            pf_v_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (bus.send_data && bus.len > MAX_L) begin
                    err_d = 1'b1;
                end else if (bus.send_data) begin
                    state_d    = PID;
                    len_d      = bus.len;
                    cnt_d      = '0;
                    snt_d      = '0;
                    pf_v_d     = 1'b0;
                    crc_d      = 16'hFFFF;
                    tx_data_d  = {~bus.pid, bus.pid};
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            PID: begin
                if (acc && len_q == '0) begin
                    state_d   = CRC_LO;
                    tx_data_d = ~crc_q[7:0];
                end else if (acc && avail) begin
                    state_d   = DATA;
                    tx_data_d = nxt_byte;
                    snt_d     = snt_q + 1'b1;
                    pf_v_d    = pf_v_q && fetch;
                end else if (acc) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (acc) crc_d = crc_nxt;
                if (acc && snt_q == len_q) begin
                    state_d   = CRC_LO;
                    tx_data_d = ~crc_nxt[7:0];
                end else if (acc && avail) begin
                    tx_data_d = nxt_byte;
                    snt_d     = snt_q + 1'b1;
                    pf_v_d    = pf_v_q && fetch;
                end else if (acc) begin
                    abort = 1'b1;
                end
            end
            CRC_LO: begin
                if (acc) begin
                    state_d   = CRC_HI;
                    tx_data_d = ~crc_q[15:8];
                end
            end
            CRC_HI: begin
                if (acc) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            pf_v_d     = 1'b0;
            err_d      = 1'b1;
        end
    end

    // State and output registers; reset takes effect immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            snt_q      <= '0;
            pf_q       <= '0;
            pf_v_q     <= 1'b0;
            crc_q      <= 16'hFFFF;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            snt_q      <= snt_d;
            pf_q       <= pf_d;
            pf_v_q     <= pf_v_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: scoreboard bench for the USB DATA packetizer
module tb_usb_tx_packetizer;
    localparam logic [1:0] EV_DONE = 2'b10;
    localparam logic [1:0] EV_ERR  = 2'b01;

    logic clk = 1'b0;
    logic reset;
    usb_tx_packetizer_if #(.LEN_W(7)) bus ();

    usb_tx_packetizer #(.MAX_LEN(64), .LEN_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [1:0] ev_q[$];
    logic [7:0] src_q[$];
    logic [7:0] pay[16];
    int         checks = 0;
    int         passed = 0;
    int         tv_cnt = 0;
    int         acc_cnt = 0;
    int         in_cnt = 0;
    int         cyc = 0;
    int         last_acc = 0;
    bit         tog = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // Monitor: scoreboard pops on every accepted byte and status pulse
    initial begin
        logic       held_v = 1'b0;
        logic [7:0] held_d = 8'h00;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                cyc++;
                if (bus.tx_valid) tv_cnt++;
                if (bus.in_valid && bus.in_ready) in_cnt++;
                if (held_v && bus.tx_valid) chk("tx_data_hold", bus.tx_data, held_d);
                if (bus.tx_valid && bus.tx_ready) begin
                    acc_cnt++;
                    last_acc = cyc;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 32'h100;
                    chk("tx_byte", bus.tx_data, e);
                end
                if (bus.done || bus.err) begin
                    if (ev_q.size() > 0) e = ev_q.pop_front();
                    else e = 32'h0;
                    chk("event", {bus.done, bus.err}, e);
                    if (bus.done) chk("done_latency", cyc - last_acc, 1);
                end
                held_v = bus.tx_valid && !bus.tx_ready;
                held_d = bus.tx_data;
            end
        end
    end

    task automatic step();
        logic take;
        @(negedge clk);
        take = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (take && src_q.size() > 0) void'(src_q.pop_front());
        bus.in_valid = src_q.size() > 0;
        bus.in_data  = src_q.size() > 0 ? src_q[0] : 8'h00;
        bus.tx_ready = tog ? !bus.tx_ready : 1'b1;
    endtask

    task automatic send(input logic [3:0] p, input logic [6:0] l);
        bus.send_data = 1'b1;
        bus.pid       = p;
        bus.len       = l;
        step();
        bus.send_data = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || ev_q.size() > 0 || bus.busy) && n < 300) begin
            step();
            n++;
        end
        chk({name, "_drain"}, exp_q.size() + ev_q.size(), 0);
        exp_q.delete();
        ev_q.delete();
        step();
    endtask

    task automatic push_pkt(input logic [3:0] p, input int n);
        logic [15:0] c = 16'hFFFF;
        exp_q.push_back({~p, p});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pay[i]);
            src_q.push_back(pay[i]);
            c = crc_bits(c, pay[i]);
        end
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
        ev_q.push_back(EV_DONE);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int b_tv, b_acc, b_in;
        reset         = 1'b1;
        bus.send_data = 1'b0;
        bus.pid       = 4'h0;
        bus.len       = 7'd0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.tx_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done_err", {bus.done, bus.err}, 0);
        step();
        reset = 1'b0;
        step();

        // len=0 DATA0
        b_tv = tv_cnt;
        exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        ev_q.push_back(EV_DONE);
        send(4'b0011, 7'd0);
        chk("len0_busy", bus.busy, 1);
        drain("len0");
        chk("len0_txvalid_cycles", tv_cnt - b_tv, 3);

        // len=1, payload 0x00, DATA1
        b_in = in_cnt;
        src_q.push_back(8'h00);
        exp_q.push_back(8'h4B); exp_q.push_back(8'h00); exp_q.push_back(8'h40); exp_q.push_back(8'hBF);
        ev_q.push_back(EV_DONE);
        send(4'b1011, 7'd1);
        drain("len1");
        chk("len1_in_transfers", in_cnt - b_in, 1);

        // "123456789" with tx_ready toggling
        tog = 1'b1;
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 9; i++) begin
            src_q.push_back(8'h31 + 8'(i));
            exp_q.push_back(8'h31 + 8'(i));
        end
        exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
        ev_q.push_back(EV_DONE);
        send(4'b0011, 7'd9);
        drain("len9");
        tog = 1'b0;
        step();

        // underrun: len=4 but only two bytes supplied
        b_acc = acc_cnt;
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        exp_q.push_back(8'h4B); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        ev_q.push_back(EV_ERR);
        send(4'b1011, 7'd4);
        drain("underrun");
        chk("underrun_bytes", acc_cnt - b_acc, 3);
        chk("underrun_busy", bus.busy, 0);
        chk("underrun_txvalid", bus.tx_valid, 0);

        // len=65 rejected
        b_tv = tv_cnt;
        ev_q.push_back(EV_ERR);
        send(4'b0011, 7'd65);
        drain("len65");
        step(); step();
        chk("len65_txvalid_never", tv_cnt - b_tv, 0);
        chk("len65_busy", bus.busy, 0);

        // len=8 with an ignored second send_data
        b_acc = acc_cnt;
        for (int i = 0; i < 8; i++) pay[i] = 8'h5A ^ 8'(i * 17);
        push_pkt(4'b0011, 8);
        send(4'b0011, 7'd8);
        step(); step(); step();
        send(4'b1011, 7'd5);
        drain("len8_resend");
        chk("len8_byte_count", acc_cnt - b_acc, 11);

        // reset in the middle of DATA
        for (int i = 0; i < 8; i++) pay[i] = 8'hA0 + 8'(i);
        push_pkt(4'b1011, 8);
        send(4'b1011, 7'd8);
        step(); step();
        chk("mid_busy_before", bus.busy, 1);
        chk("mid_txvalid_before", bus.tx_valid, 1);
        chk("mid_inready_before", bus.in_ready, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_txvalid", bus.tx_valid, 0);
        chk("mid_rst_inready", bus.in_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        exp_q.delete();
        ev_q.delete();
        src_q.delete();
        bus.in_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("mid_rst_no_pulse", {bus.done, bus.err}, 0);
        b_tv = tv_cnt;
        exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        ev_q.push_back(EV_DONE);
        send(4'b0011, 7'd0);
        drain("post_rst_len0");
        chk("post_rst_txvalid_cycles", tv_cnt - b_tv, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
